// File: rtl/apb_req_arbiter_if.sv
// Requester-side, master-command and APB bus-tap signals of the APB request arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface apb_req_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            req_write_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            done_o;
  logic                          err_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic                          busy_o;
  logic                          evnt_trig_o;
  logic [ADDR_WIDTH-1:0]         addr_o;
  logic [DATA_WIDTH-1:0]         data_o;
  logic                          pwrite_o;
  logic                          apb_psel_i;
  logic                          apb_penable_i;
  logic                          apb_pready_i;
  logic [DATA_WIDTH-1:0]         apb_prdata_i;

  modport master (
    input  req_i, req_addr_i, req_wdata_i, req_write_i,
    input  apb_psel_i, apb_penable_i, apb_pready_i, apb_prdata_i,
    output gnt_o, done_o, err_o, rdata_o, busy_o,
    output evnt_trig_o, addr_o, data_o, pwrite_o
  );

  modport slave (
    output req_i, req_addr_i, req_wdata_i, req_write_i,
    output apb_psel_i, apb_penable_i, apb_pready_i, apb_prdata_i,
    input  gnt_o, done_o, err_o, rdata_o, busy_o,
    input  evnt_trig_o, addr_o, data_o, pwrite_o
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin scheduler sharing one APB master among NUM_REQ requesters: grants one
// request, triggers the master, watches the bus for completion or timeout, reports back.
module apb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_req_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic                    evnt_trig_q, evnt_trig_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    pwrite_q, pwrite_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Next-state and registered-output computation
  always_comb begin
    logic        found;
    int unsigned k;

    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    evnt_trig_d  = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    pwrite_d     = pwrite_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    found        = 1'b0;
    k            = 0;

    unique case (state_q)
      IDLE: begin
        // Search upward from the requester after the last winner, wrapping around
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
          k = 32'(last_grant_q) + i;
          if (k >= NUM_REQ) k = k - NUM_REQ;
          if (!found && bus.req_i[IDX_W'(k)]) begin
            found = 1'b1;
            sel_d = IDX_W'(k);
          end
        end
        if (found) begin
          state_d        = ISSUE;
          gnt_d          = '0;
          gnt_d[sel_d]   = 1'b1;
          addr_d         = ADDR_WIDTH'(bus.req_addr_i >> (32'(sel_d) * ADDR_WIDTH));
          data_d         = DATA_WIDTH'(bus.req_wdata_i >> (32'(sel_d) * DATA_WIDTH));
          pwrite_d       = bus.req_write_i[sel_d];
          evnt_trig_d    = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion has priority over a timeout reached in the same cycle
        if (bus.apb_psel_i && bus.apb_penable_i && bus.apb_pready_i) begin
          rdata_d       = bus.apb_prdata_i;
          err_d         = 1'b0;
          done_d[sel_q] = 1'b1;
          state_d       = DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
            err_d         = 1'b1;
            done_d[sel_q] = 1'b1;
            state_d       = DONE;
          end
        end
      end
      DONE: begin
        last_grant_d = sel_q;
        gnt_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      evnt_trig_q  <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      pwrite_q     <= 1'b0;
      sel_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      evnt_trig_q  <= evnt_trig_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pwrite_q     <= pwrite_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.evnt_trig_o = evnt_trig_q;
  assign bus.addr_o      = addr_q;
  assign bus.data_o      = data_q;
  assign bus.pwrite_o    = pwrite_q;

endmodule
